// File: rtl/handshake_syn.sv
// handshake_syn: single-clock four-phase req/ack word transfer with a held data
// register and SYNC_STAGES-deep flop synchronizers on the request and ack paths.
// The synchronizer chains are kept so the block can later be split across clocks.
// Optional build macro HANDSHAKE_SYN_DROP_CNT_EN adds a saturating drop_cnt output
// counting writer request edges ignored while busy or while the ack is still seen.
module handshake_syn #(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_req,
  output logic                  wr_ack,
  output logic                  wr_busy,
  output logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ack
`ifdef HANDSHAKE_SYN_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    wr_req_q;
  logic                    req_flag_q, req_flag_d;
  logic [DATA_WIDTH-1:0]   data_hold_q, data_hold_d;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [SYNC_STAGES-1:0]  req_sync_q;
  logic [SYNC_STAGES-1:0]  ack_sync_q;

  logic ack_sync;
  logic wr_rise;
  logic capture;
  logic rd_load;

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];
  assign wr_rise  = wr_req & ~wr_req_q;
  assign capture  = wr_rise & (state_q == S_IDLE) & ~ack_sync;
  // rd_data follows data_hold only on the edge where the last req stage rises
  assign rd_load  = req_sync_q[SYNC_STAGES-2] & ~req_sync_q[SYNC_STAGES-1];

  // Writer FSM next-state: capture, wait for ack with wr_req low, wait for ack release
  always_comb begin
    state_d     = state_q;
    req_flag_d  = req_flag_q;
    data_hold_d = data_hold_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          data_hold_d = wr_data;
          req_flag_d  = 1'b1;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_sync && !wr_req) begin
          req_flag_d = 1'b0;
          state_d    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!ack_sync) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        req_flag_d = 1'b0;
      end
    endcase
  end

  // Writer-side registers: FSM, latched request flag, held word, request edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_flag_q  <= 1'b0;
      data_hold_q <= '0;
      wr_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_flag_q  <= req_flag_d;
      data_hold_q <= data_hold_d;
      wr_req_q    <= wr_req;
    end
  end

  // Request and acknowledge synchronizer chains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_sync_q <= '0;
      ack_sync_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_flag_q};
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], rd_ack};
    end
  end

  // Reader data register, loaded together with the rising valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_load) begin
      rd_data_q <= data_hold_q;
    end
  end

`ifdef HANDSHAKE_SYN_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating count of request edges that did not start a transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (wr_rise && !capture && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign rd_req  = req_sync_q[SYNC_STAGES-1];
  assign rd_data = rd_data_q;
  assign wr_busy = (state_q != S_IDLE);
  assign wr_ack  = ack_sync & (state_q != S_IDLE);

endmodule

// File: tb/tb_handshake_syn.sv
// Bench for handshake_syn: transaction-level reference model with a scoreboard of
// expected words and their valid cycles, a per-cycle output monitor, directed
// scenarios followed by randomized writer/reader activity.
module tb_handshake_syn;
  localparam int DW   = 12;
  localparam int S    = 2;
  localparam int HMAX = 20000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_req = 1'b0;
  logic          rd_ack = 1'b0;
  logic          wr_ack, wr_busy, rd_req;
  logic [DW-1:0] rd_data;
`ifdef HANDSHAKE_SYN_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  always #5 clk = ~clk;

  handshake_syn #(.DATA_WIDTH(DW), .SYNC_STAGES(S)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_data (wr_data),
    .wr_req  (wr_req),
    .wr_ack  (wr_ack),
    .wr_busy (wr_busy),
    .rd_req  (rd_req),
    .rd_data (rd_data),
    .rd_ack  (rd_ack)
`ifdef HANDSHAKE_SYN_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_REQ, M_REL} phase_t;
  typedef struct {logic [DW-1:0] data; int due;} item_t;

  int     cyc = 0;
  int     base = 0;
  bit     ackh [HMAX];
  bit     wrh  [HMAX];
  bit     flagh[HMAX];
  phase_t phase = M_IDLE;
  bit     m_flag = 1'b0;
  int     m_drops = 0;
  bit     exp_busy = 1'b0, exp_ack = 1'b0, exp_rdreq = 1'b0;
  item_t  sbq[$];
  logic [DW-1:0] last_word = '0;
  bit     prev_rdreq = 1'b0;

  int checks = 0;
  int errors = 0;

  bit auto_rd = 1'b1;
  bit fast    = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // reader ack as seen by the writer after edge k: rd_ack sampled S-1 edges earlier
  function automatic bit ack_at(input int k);
    return (k - S + 1 > base) ? ackh[k - S + 1] : 1'b0;
  endfunction

  function automatic bit flag_at(input int k);
    return (k > base) ? flagh[k] : 1'b0;
  endfunction

  task automatic model_reset();
    base       = cyc;
    phase      = M_IDLE;
    m_flag     = 1'b0;
    m_drops    = 0;
    exp_busy   = 1'b0;
    exp_ack    = 1'b0;
    exp_rdreq  = 1'b0;
    sbq.delete();
    last_word  = '0;
    prev_rdreq = 1'b0;
  endtask

  task automatic model_step(input int n);
    bit    prev_wr, rise, ack_before;
    item_t it;
    ackh[n]    = rd_ack;
    wrh[n]     = wr_req;
    prev_wr    = (n - 1 > base) ? wrh[n - 1] : 1'b0;
    rise       = wr_req && !prev_wr;
    ack_before = ack_at(n - 1);
    case (phase)
      M_IDLE: begin
        if (rise && !ack_before) begin
          m_flag  = 1'b1;
          phase   = M_REQ;
          it.data = wr_data;
          it.due  = n + S;
          sbq.push_back(it);
        end else if (rise && m_drops < 255) begin
          m_drops++;
        end
      end
      M_REQ: begin
        if (rise && m_drops < 255) m_drops++;
        if (ack_before && !wr_req) begin
          m_flag = 1'b0;
          phase  = M_REL;
        end
      end
      default: begin
        if (rise && m_drops < 255) m_drops++;
        if (!ack_before) phase = M_IDLE;
      end
    endcase
    flagh[n]  = m_flag;
    exp_busy  = (phase != M_IDLE);
    exp_ack   = ack_at(n) && exp_busy;
    exp_rdreq = flag_at(n - S);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc >= HMAX - 2) begin
        $display("FAIL cycle_budget: got %0d expected below %0d", cyc, HMAX - 2);
        $fatal(1, "cycle budget exhausted");
      end
      if (reset) model_reset();
      else model_step(cyc);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      chk("rd_req", rd_req, exp_rdreq);
      chk("wr_busy", wr_busy, exp_busy);
      chk("wr_ack", wr_ack, exp_ack);
      if (rd_req && !prev_rdreq) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_rd_req: got rd_data %0h expected no transfer (cycle %0d)", rd_data, cyc);
        end else begin
          it = sbq.pop_front();
          chk("rd_req_cycle", cyc, it.due);
          chk("rd_data_on_valid", rd_data, it.data);
          last_word = it.data;
        end
      end
      prev_rdreq = rd_req;
      chk("rd_data_hold", rd_data, last_word);
`ifdef HANDSHAKE_SYN_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, m_drops);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_rd && rd_ack != rd_req && (fast || $urandom_range(0, 1) == 1))
      rd_ack = rd_req;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(!wr_busy && !rd_req && !rd_ack && !wr_ack) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy %0b rd_req %0b expected idle within %0d cycles", wr_busy, rd_req, budget);
    end
    repeat (S + 2) step();
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    wr_data = d;
    wr_req  = 1'b1;
    step();
    step();
    wr_req  = 1'b0;
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_rd_req", rd_req, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_wr_busy", wr_busy, 0);
    chk("rst_rd_data", rd_data, 0);
    wr_req = 1'b0;
    rd_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_req", rd_req, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_wr_busy", wr_busy, 0);
    reset = 1'b0;
    step();

    // basic transfer
    pulse(12'hA5C);
    wait_idle(60);
    chk("basic_data", rd_data, 12'hA5C);

    // data hold after transfer
    pulse(12'h3F1);
    wait_idle(60);
    wr_data = 12'h000;
    repeat (20) step();
    chk("hold_data", rd_data, 12'h3F1);

    // second request edge while busy is ignored
    auto_rd = 1'b0;
    wr_data = 12'h0AB;
    wr_req  = 1'b1;
    step();
    wr_req  = 1'b0;
    step();
    step();
    wr_data = 12'h777;
    wr_req  = 1'b1;
    step();
    wr_req  = 1'b0;
    step();
    auto_rd = 1'b1;
    wait_idle(60);
    chk("busy_ignore_data", rd_data, 12'h0AB);
`ifdef HANDSHAKE_SYN_DROP_CNT_EN
    chk("busy_ignore_drop", drop_cnt, 1);
`endif

    // held request: no retrigger, release waits for wr_req low
    wr_data = 12'h5A5;
    wr_req  = 1'b1;
    repeat (15) step();
    chk("held_busy", wr_busy, 1);
    chk("held_ack", wr_ack, 1);
    wr_req = 1'b0;
    wait_idle(60);
    chk("held_data", rd_data, 12'h5A5);

    // reset while rd_req is high, then a clean transfer
    wr_data = 12'h456;
    wr_req  = 1'b1;
    step();
    wr_req  = 1'b0;
    k = 0;
    while (!rd_req && k < 20) begin
      step();
      k++;
    end
    chk("pre_reset_rd_req", rd_req, 1);
    mid_reset();
    pulse(12'h123);
    wait_idle(60);
    chk("post_reset_data", rd_data, 12'h123);

    // stray ack while idle blocks capture
    auto_rd = 1'b0;
    rd_ack  = 1'b1;
    repeat (4) step();
    pulse(12'h9C3);
    repeat (3) step();
    chk("stray_rd_req", rd_req, 0);
    chk("stray_wr_ack", wr_ack, 0);
    chk("stray_busy", wr_busy, 0);
    rd_ack = 1'b0;
    repeat (4) step();
    pulse(12'h9C3);
    auto_rd = 1'b1;
    wait_idle(60);
    chk("stray_then_data", rd_data, 12'h9C3);

    // randomized writer and reader activity
    fast = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) wr_req = ~wr_req;
      wr_data = DW'($urandom);
      if ($urandom_range(0, 19) == 0) rd_ack = ~rd_ack;
    end
    wr_req = 1'b0;
    fast   = 1'b1;
    wait_idle(200);

    repeat (5) step();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
